input_scan_ctrl: RTL and testbench
==================================

// Module: input_scan_ctrl
// PURPOSE
//  Parametrised board input controller for the A7-T100 at 100 MHz. Generalises
//  the fixed 5-button / 16-switch front end to NUM_BTN buttons and NUM_SW switches.
//  Every input is synchronised. Buttons are debounced by a per-channel FSM that
//  emits press/release pulses. Switches give a synchronised bus, an LED mirror
//  and a change strobe. Sits between the board pins and user logic.
// PARAMETERS
//  NUM_BTN          5           number of push-button channels (>=1)
//  NUM_SW           16          number of slide switches / LEDs (>=1)
//  DEBOUNCE_CYCLES  1_000_000   stable cycles before a button level is accepted (10 ms; >=1)
//  HOLD_CYCLES      50_000_000  hold time before the first auto-repeat pulse (500 ms)
//  REPEAT_CYCLES    10_000_000  auto-repeat period while held (100 ms)
// PORTS
//  CLK100_I     in   1        100 MHz board clock; the only clock
//  RST_I        in   1        reset, asynchronous, active-high
//  BTN_I        in   NUM_BTN  raw button pins
//  SW_I         in   NUM_SW   raw switch pins
//  DBTN_O       out  NUM_BTN  debounced button level
//  BTN_PRESS_O  out  NUM_BTN  1-cycle pulse on an accepted 0->1
//  BTN_REL_O    out  NUM_BTN  1-cycle pulse on an accepted 1->0
//  BTN_RPT_O    out  NUM_BTN  1-cycle auto-repeat pulse (tied 0 unless the macro is defined)
//  SW_O         out  NUM_SW   synchronised switch levels
//  SW_LED_O     out  NUM_SW   LED drive, registered copy of SW_O
//  SW_CHG_O     out  1        1-cycle pulse when any bit of SW_O changed
// BEHAVIOUR
//  - Interface: one clock, CLK100_I; reset RST_I is asynchronous and active-high.
//    While RST_I is high, all flops and outputs are 0 and every FSM is in S_LO.
//  - Synchronisers: a 2-FF chain per input bit. The second stage (s2) is the
//    only signal the downstream logic sees.
//  - Button FSM, per channel; state encoding comes from the package:
//     S_LO:  if s2=1, go to S_CHK_HI and set cnt=1.
//     S_CHK_HI: if s2=0, return to S_LO and clear cnt (bounce).
//       Else if cnt==DEBOUNCE_CYCLES, go to S_HI with DBTN=1 and PRESS=1 for
//       one cycle. Otherwise cnt++.
//     S_HI and S_CHK_LO: the mirror of the above, ending with DBTN=0 and REL=1.
//     DEBOUNCE_CYCLES=1: the check state is skipped and the level is accepted
//       on the first sample.
//  - Latency: a clean pin edge moves DBTN_O after exactly DEBOUNCE_CYCLES+2 edges.
//    PRESS and REL assert on the same edge DBTN_O changes.
//  - A glitch shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
//  - Channels are fully independent. Simultaneous presses give simultaneous pulses.
//  - A button held through reset release is treated as a fresh press: PRESS
//    fires DEBOUNCE_CYCLES+2 edges after RST_I falls.
//  - Counter width: CNT_W = $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES,REPEAT_CYCLES)+1).
//    Counters saturate and never wrap.
//  - Switches: SW_O = s2, no debounce. SW_LED_O = SW_O delayed 1 cycle.
//    SW_CHG_O = |(SW_O ^ SW_LED_O), so it is high for exactly 1 cycle per change.
// CONFIGURATION
//  INPUT_SCAN_AUTOREPEAT_EN
//  Defined:
//   - Each channel has a repeat counter that starts on PRESS.
//   - The first BTN_RPT_O pulse comes HOLD_CYCLES edges after PRESS, then one
//     every REPEAT_CYCLES while in S_HI or S_CHK_LO.
//   - Leaving for S_HI->S_CHK_LO does not stop the repeat. Reaching S_LO
//     clears the counter and suppresses any pulse on that edge.
//  Not defined:
//   - BTN_RPT_O is constant 0 and no repeat counters are synthesised.
//   - The port list is unchanged.
// STRUCTURE
//  - Package input_scan_pkg holds:
//    - btn_state_t with the states S_LO, S_CHK_HI, S_HI, S_CHK_LO
//    - the localparam CLK_HZ=100_000_000
//    - the helper function cnt_width()
//  - Sub-module btn_debounce_ch holds one button channel: sync, FSM, counter and
//    optional repeat. It is instantiated NUM_BTN times in a generate loop.
//  - The switch sync and change detection stay in the top level.
// TESTING  (bench: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, NUM_BTN=5)
//  - Reset: assert RST_I mid-press -> all outputs 0 on the same edge, with no
//    clock needed; after release, PRESS fires 6 edges later if the pin is still high.
//  - Clean press on BTN_I[2] -> DBTN_O[2]=1 and BTN_PRESS_O[2]=1 for one cycle,
//    6 edges after the pin edge. Release -> BTN_REL_O[2] 6 edges later.
//  - Bounce: a 3-cycle high glitch, then 0 -> no PRESS, DBTN_O stays 0.
//    High 3 / low 1 / high 4 -> PRESS occurs once.
//  - Simultaneous BTN_I=5'b10001 -> PRESS_O=5'b10001 on the same edge; others stay 0.
//  - With INPUT_SCAN_AUTOREPEAT_EN defined, hold BTN_I[0] for 60 cycles:
//    - RPT pulses at PRESS+20, +28, +36, +44, +52
//    - none after the release reaches S_LO
//    - without the macro, RPT stays 0
//  - SW_I changes 16'h0000->16'h00A5 -> SW_O follows after 2 edges, SW_LED_O
//    after 3, SW_CHG_O high for exactly 1 cycle.

Source files
------------

// File: rtl/input_scan_pkg.sv
// Shared types and helpers for the board input scan controller.
// Holds the button FSM state encoding, the board clock rate and the counter sizing helper.
// S_LO must stay at encoding 0 so that a cleared state register means "released".
package input_scan_pkg;

  // Board clock frequency the default debounce/hold/repeat counts are derived from.
  localparam int unsigned CLK_HZ = 100_000_000;

  // Per-channel button FSM states.
  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } btn_state_t;

  // Width large enough to hold the largest of the three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned deb,
                                            input int unsigned hold,
                                            input int unsigned rpt);
    int unsigned m;
    m = deb;
    if (hold > m) m = hold;
    if (rpt > m) m = rpt;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, debounce FSM, press/release pulses, optional auto-repeat.
// Latency: a clean pin edge moves dbtn_o after DEBOUNCE_CYCLES+2 clock edges; pulses share that edge.
// Optional feature macro: INPUT_SCAN_AUTOREPEAT_EN (rpt_o tied low and no repeat counter when undefined).
module btn_debounce_ch
  import input_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic dbtn_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);

  logic             s1_q, s2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dbtn_q, dbtn_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Two-stage synchroniser; only s2_q is seen by the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Next-state logic: cnt holds the number of consecutive samples seen at the new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbtn_d  = dbtn_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    unique case (state_q)
      S_LO: begin
        if (s2_q) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = S_HI;
            dbtn_d  = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_CHK_HI: begin
        if (!s2_q) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_C) begin
          state_d = S_HI;
          dbtn_d  = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HI: begin
        if (!s2_q) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = S_LO;
            dbtn_d  = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_CHK_LO: begin
        if (s2_q) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_C) begin
          state_d = S_LO;
          dbtn_d  = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
        dbtn_d  = 1'b0;
      end
    endcase
  end

  // FSM state, debounce counter and registered level/pulse outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      dbtn_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbtn_q  <= dbtn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign dbtn_o  = dbtn_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

`ifdef INPUT_SCAN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RPT_C  = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_q, rpt_d;

  // Repeat timer: restarts on the press edge, first period HOLD, then REPEAT; dropping to S_LO wins.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_d       = 1'b0;
    rpt_inc     = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;
    if (state_d == S_LO) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
    end else if (press_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == S_HI || state_q == S_CHK_LO) begin
      if (rpt_inc == (rpt_first_q ? HOLD_C : RPT_C)) begin
        rpt_d       = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_inc;
      end
    end
  end

  // Repeat timer registers and registered repeat pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      rpt_q       <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/input_scan_ctrl.sv
// Board input front end: NUM_BTN debounced buttons with press/release/repeat pulses, NUM_SW synchronised switches.
// Latency: buttons DEBOUNCE_CYCLES+2 edges pin-to-output; switches 2 edges to SW_O, 3 to SW_LED_O.
// Optional feature macro: INPUT_SCAN_AUTOREPEAT_EN enables BTN_RPT_O; no backpressure, outputs are free-running.
module input_scan_ctrl
  import input_scan_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic               CLK100_I,
  input  logic               RST_I,
  input  logic [NUM_BTN-1:0] BTN_I,
  input  logic [NUM_SW-1:0]  SW_I,
  output logic [NUM_BTN-1:0] DBTN_O,
  output logic [NUM_BTN-1:0] BTN_PRESS_O,
  output logic [NUM_BTN-1:0] BTN_REL_O,
  output logic [NUM_BTN-1:0] BTN_RPT_O,
  output logic [NUM_SW-1:0]  SW_O,
  output logic [NUM_SW-1:0]  SW_LED_O,
  output logic               SW_CHG_O
);

  // One independent debounce channel per button.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk_i   (CLK100_I),
      .rst_i   (RST_I),
      .btn_i   (BTN_I[g]),
      .dbtn_o  (DBTN_O[g]),
      .press_o (BTN_PRESS_O[g]),
      .rel_o   (BTN_REL_O[g]),
      .rpt_o   (BTN_RPT_O[g])
    );
  end

  logic [NUM_SW-1:0] sw_s1_q, sw_s2_q, sw_led_q;

  // Switch synchroniser plus the one-cycle-delayed LED copy used for change detection.
  always_ff @(posedge CLK100_I or posedge RST_I) begin
    if (RST_I) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      sw_led_q <= '0;
    end else begin
      sw_s1_q  <= SW_I;
      sw_s2_q  <= sw_s1_q;
      sw_led_q <= sw_s2_q;
    end
  end

  assign SW_O     = sw_s2_q;
  assign SW_LED_O = sw_led_q;
  // High exactly while the LED copy lags the synchronised bus, i.e. one cycle per change.
  assign SW_CHG_O = |(sw_s2_q ^ sw_led_q);

endmodule

// File: tb/tb_input_scan_ctrl.sv
module tb_input_scan_ctrl;

  localparam int NB = 5;
  localparam int NS = 16;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NS-1:0] sw;
  logic [NB-1:0] dbtn, press, rel, rpt;
  logic [NS-1:0] sw_o, sw_led;
  logic          sw_chg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt [NB];
  int rel_cnt [NB];
  int rpt_cnt [NB];
  int rpt_t [$];

  input_scan_ctrl #(
    .NUM_BTN         (NB),
    .NUM_SW          (NS),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8)
  ) dut (
    .CLK100_I    (clk),
    .RST_I       (rst),
    .BTN_I       (btn),
    .SW_I        (sw),
    .DBTN_O      (dbtn),
    .BTN_PRESS_O (press),
    .BTN_REL_O   (rel),
    .BTN_RPT_O   (rpt),
    .SW_O        (sw_o),
    .SW_LED_O    (sw_led),
    .SW_CHG_O    (sw_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse tally and repeat timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        press_cnt[i] += int'(press[i]);
        rel_cnt[i]   += int'(rel[i]);
        rpt_cnt[i]   += int'(rpt[i]);
      end
      if (rpt[0]) rpt_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int c0;
  int p0;
  int r0;
  int rp4;
  int exp_n;

  initial begin
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      rpt_cnt[i]   = 0;
    end
    rst = 1'b1;
    btn = '0;
    sw  = '0;
    tick(3);

    // Reset state
    check("rst_dbtn",  32'(dbtn),   32'h0);
    check("rst_press", 32'(press),  32'h0);
    check("rst_rel",   32'(rel),    32'h0);
    check("rst_rpt",   32'(rpt),    32'h0);
    check("rst_sw",    32'(sw_o),   32'h0);
    check("rst_led",   32'(sw_led), 32'h0);
    check("rst_chg",   32'(sw_chg), 32'h0);
    rst = 1'b0;
    tick(2);

    // Clean press and release on channel 2
    btn = 5'b00100;
    tick(5);
    check("p2_early_dbtn",  32'(dbtn),  32'h0);
    check("p2_early_press", 32'(press), 32'h0);
    tick(1);
    check("p2_dbtn",  32'(dbtn),  32'h04);
    check("p2_press", 32'(press), 32'h04);
    tick(1);
    check("p2_press_end", 32'(press), 32'h0);
    check("p2_dbtn_hold", 32'(dbtn),  32'h04);
    btn = 5'b00000;
    tick(5);
    check("r2_early_dbtn", 32'(dbtn), 32'h04);
    check("r2_early_rel",  32'(rel),  32'h0);
    tick(1);
    check("r2_dbtn", 32'(dbtn), 32'h0);
    check("r2_rel",  32'(rel),  32'h04);
    tick(1);
    check("r2_rel_end", 32'(rel), 32'h0);
    tick(3);

    // Bounce: a short glitch is ignored
    p0 = press_cnt[2];
    btn = 5'b00100;
    tick(3);
    btn = 5'b00000;
    tick(10);
    check("glitch_dbtn",  32'(dbtn), 32'h0);
    check("glitch_press", 32'(press_cnt[2] - p0), 32'd0);

    // High 3 / low 1 / high 4 gives exactly one press (and its release)
    p0 = press_cnt[2];
    r0 = rel_cnt[2];
    btn = 5'b00100; tick(3);
    btn = 5'b00000; tick(1);
    btn = 5'b00100; tick(4);
    btn = 5'b00000; tick(14);
    check("bounce_press", 32'(press_cnt[2] - p0), 32'd1);
    check("bounce_rel",   32'(rel_cnt[2] - r0),   32'd1);
    check("bounce_dbtn",  32'(dbtn), 32'h0);

    // Simultaneous press on channels 0 and 4, held 60 cycles for auto-repeat
    rpt_t.delete();
    rp4 = rpt_cnt[4];
    btn = 5'b10001;
    c0 = cyc;
    tick(5);
    check("sim_early_press", 32'(press), 32'h0);
    tick(1);
    check("sim_press", 32'(press), 32'h11);
    check("sim_dbtn",  32'(dbtn),  32'h11);
    tick(1);
    check("sim_press_end", 32'(press), 32'h0);
    tick(53);
    btn = 5'b00000;
    tick(5);
    check("sim_rel_early", 32'(dbtn), 32'h11);
    tick(1);
    check("sim_rel",      32'(rel),  32'h11);
    check("sim_rel_dbtn", 32'(dbtn), 32'h0);
    tick(20);
`ifdef INPUT_SCAN_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 0;
`endif
    check("rpt_count0", 32'(rpt_t.size()), 32'(exp_n));
    check("rpt_count4", 32'(rpt_cnt[4] - rp4), 32'(exp_n));
    for (int i = 0; i < exp_n && i < rpt_t.size(); i++)
      check("rpt_time", 32'(rpt_t[i] - c0), 32'(26 + 8 * i));
    check("rpt_idle", 32'(rpt), 32'h0);

    // Switch path
    sw = 16'h00A5;
    tick(1);
    check("sw_e1", 32'(sw_o), 32'h0);
    tick(1);
    check("sw_e2",      32'(sw_o),   32'h00A5);
    check("sw_led_e2",  32'(sw_led), 32'h0);
    check("sw_chg_e2",  32'(sw_chg), 32'h1);
    tick(1);
    check("sw_led_e3",  32'(sw_led), 32'h00A5);
    check("sw_chg_e3",  32'(sw_chg), 32'h0);
    tick(2);
    check("sw_chg_idle", 32'(sw_chg), 32'h0);

    // Reset mid-press: outputs clear without a clock edge, held pin re-presses after release
    btn = 5'b00010;
    tick(6);
    check("rp_press", 32'(press), 32'h02);
    rst = 1'b1;
    #1;
    check("rp_async_dbtn",  32'(dbtn),  32'h0);
    check("rp_async_press", 32'(press), 32'h0);
    check("rp_async_sw",    32'(sw_o),  32'h0);
    check("rp_async_led",   32'(sw_led), 32'h0);
    tick(3);
    rst = 1'b0;
    tick(5);
    check("rp_early", 32'(press), 32'h0);
    tick(1);
    check("rp_repress", 32'(press), 32'h02);
    check("rp_dbtn",    32'(dbtn),  32'h02);
    btn = 5'b00000;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
